// File: rtl/phys_free_list.sv
// Physical-register free list for rename: hands out free tags speculatively,
// reclaims old mappings at commit, and rolls the head back on a flush.
module phys_free_list #(
  parameter int NUM_PHYS  = 64,
  parameter int NUM_ARCH  = 32,
  parameter int PHYS_BITS = $clog2(NUM_PHYS),
  parameter int DEPTH     = NUM_PHYS - NUM_ARCH,
  parameter int PTR_BITS  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_valid,
  output logic [PHYS_BITS-1:0] alloc_phys,
  input  logic                 release_en,
  input  logic [PHYS_BITS-1:0] release_phys,
  input  logic                 flush,
  output logic [PTR_BITS-1:0]  free_count,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int IDX_BITS = PTR_BITS - 1;

  logic [PHYS_BITS-1:0] mem_q [DEPTH];
  logic [PTR_BITS-1:0]  spec_head_q, spec_head_d;
  logic [PTR_BITS-1:0]  commit_head_q, commit_head_d;
  logic [PTR_BITS-1:0]  tail_q, tail_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 alloc_fire, release_fire, list_full;

  // Outputs come only from registered state; no input reaches them combinationally.
  assign free_count    = tail_q - spec_head_q;
  assign alloc_valid   = (free_count != '0);
  assign alloc_phys    = mem_q[spec_head_q[IDX_BITS-1:0]];
  assign list_full     = (free_count == PTR_BITS'(DEPTH));
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  assign alloc_fire   = alloc_req && alloc_valid && !flush;
  assign release_fire = release_en && !list_full;

  always_comb begin
    spec_head_d   = spec_head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    if (release_fire) begin
      tail_d        = tail_q + PTR_BITS'(1);
      commit_head_d = commit_head_q + PTR_BITS'(1);
    end
    // A same-cycle release retires one more allocation before the rollback.
    if (flush)
      spec_head_d = commit_head_q + PTR_BITS'(release_fire);
    else if (alloc_fire)
      spec_head_d = spec_head_q + PTR_BITS'(1);

    if (release_en && list_full)
      overflow_d = 1'b1;
    if (alloc_req && !alloc_valid)
      underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_BITS'(DEPTH);
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Each slot resets to its initial free tag, so the array lives in flops.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        mem_q[gi] <= PHYS_BITS'(NUM_ARCH + gi);
      else if (release_fire && (tail_q[IDX_BITS-1:0] == IDX_BITS'(gi)))
        mem_q[gi] <= release_phys;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: a queue-based model of free and
// in-flight tags predicts every allocation; a monitor checks them as they fire.
module tb_phys_free_list;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [5:0] alloc_phys;
  logic       release_en = 1'b0;
  logic [5:0] release_phys = '0;
  logic       flush = 1'b0;
  logic [5:0] free_count;
  logic       overflow_err;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  int fq[$];        // free tags in hand-out order
  int inflight[$];  // allocated, not yet retired, oldest first
  int exp_q[$];     // expected alloc_phys per allocation
  bit m_ovf, m_unf;

  phys_free_list dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_phys(alloc_phys),
    .release_en(release_en), .release_phys(release_phys), .flush(flush),
    .free_count(free_count), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    inflight.delete();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) fq.push_back(32 + i);
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 1'b0; release_en = 1'b0; flush = 1'b0; release_phys = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_state();
    chk("free_count", int'(free_count), fq.size());
    chk("alloc_valid", int'(alloc_valid), int'(fq.size() != 0));
    if (fq.size() != 0) chk("alloc_phys", int'(alloc_phys), fq[0]);
    chk("overflow_err", int'(overflow_err), int'(m_ovf));
    chk("underflow_err", int'(underflow_err), int'(m_unf));
  endtask

  // One clock cycle: called at posedge+1, drives inputs, advances the model.
  task automatic step(bit a, bit r, int rp, bit f);
    bit fire_a, fire_r;
    check_state();
    alloc_req = a; release_en = r; release_phys = 6'(rp); flush = f;
    #1;
    chk("valid_no_comb_path", int'(alloc_valid), int'(fq.size() != 0));
    fire_a = a && (fq.size() != 0) && !f;
    fire_r = r && (fq.size() != DEPTH);
    if (a && fq.size() == 0) m_unf = 1'b1;
    if (r && fq.size() == DEPTH) m_ovf = 1'b1;
    if (fire_a) begin
      exp_q.push_back(fq[0]);
      inflight.push_back(fq.pop_front());
    end
    if (fire_r) begin
      if (inflight.size() != 0) void'(inflight.pop_front());
      fq.push_back(rp);
    end
    if (f) begin
      fq = {inflight, fq};
      inflight.delete();
    end
    @(posedge clk); #1;
    alloc_req = 1'b0; release_en = 1'b0; flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && alloc_req && alloc_valid && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL alloc_unexpected: got tag %0d expected no allocation", alloc_phys);
      end else begin
        automatic int e = exp_q.pop_front();
        chk("alloc_tag", int'(alloc_phys), e);
        $display("alloc tag %0d (expected %0d) free_count %0d", alloc_phys, e, free_count);
      end
    end
  end

  initial begin
    do_reset();

    // Drain the list, then one alloc too many.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Release into an empty list: not allocatable until the next cycle.
    step(0, 1, 5, 0);
    check_state();

    // Alloc and release together keep the count steady; 7s reappear after wrap.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 7, 0);
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0);

    // Alloc 3, release 1, then flush.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 10, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // Flush and release in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 10, 1);
    step(1, 0, 0, 0);
    check_state();

    // Release into a full list, then asynchronous reset mid-cycle.
    do_reset();
    step(0, 1, 3, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check_state();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_free_count", int'(free_count), 32);
    chk("async_rst_alloc_valid", int'(alloc_valid), 1);
    chk("async_rst_alloc_phys", int'(alloc_phys), 32);
    chk("async_rst_overflow", int'(overflow_err), 0);
    chk("async_rst_underflow", int'(underflow_err), 0);
    do_reset();

    // Randomized traffic with commits only for real in-flight allocations.
    for (int n = 0; n < 3000; n++) begin
      bit a, r, f;
      a = ($urandom_range(0, 99) < 55);
      r = (inflight.size() != 0) && ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 4);
      if (f && fq.size() == 0) a = 1'b0;
      step(a, r, $urandom_range(0, 63), f);
    end
    check_state();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
